// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Purpose  : Handshaked data-memory responder with programmable wait states;
//            one outstanding word read or byte-enabled write at a time.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0]  CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic             acc_we;
  logic [31:0]      acc_addr;
  logic [31:0]      acc_wdata;
  logic [3:0]       acc_be;
  logic [32:0]      off_ext;
  logic [31:0]      word_off;
  logic             acc_err;
  logic [IDX_W-1:0] acc_idx;
  logic             mem_wr;

  // With zero wait states the access happens on the accept edge, so the
  // live request inputs feed the datapath; otherwise the captured copy does.
  always_comb begin
    if (state_q == ST_IDLE) begin
      acc_we    = req_we;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
      acc_be    = req_be;
    end else begin
      acc_we    = we_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      acc_be    = be_q;
    end
  end

  // Bit 32 is the borrow: an address below ADDR_BASE wraps and is rejected.
  assign off_ext  = {1'b0, acc_addr} - {1'b0, ADDR_BASE};
  assign word_off = off_ext[31:0] >> 2;
  assign acc_err  = (acc_addr[1:0] != 2'b00) | off_ext[32] | (word_off >= DEPTH_WORDS);
  assign acc_idx  = word_off[IDX_W-1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    mem_wr  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          be_d    = req_be;
          if (WAIT_CYCLES == 0) begin
            state_d = ST_RESP;
            mem_wr  = acc_we & ~acc_err;
            err_d   = acc_err;
            rdata_d = (acc_err | acc_we) ? 32'h0 : mem_q[acc_idx];
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_RESP;
          mem_wr  = acc_we & ~acc_err;
          err_d   = acc_err;
          rdata_d = (acc_err | acc_we) ? 32'h0 : mem_q[acc_idx];
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
          rdata_d = 32'h0;
          err_d   = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      be_q    <= 4'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Storage is not reset; a reset on the commit edge cancels the write.
  always_ff @(posedge clk) begin
    if (mem_wr && !reset) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_be[i]) begin
          mem_q[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
        end
      end
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_responder
// Purpose  : Self-checking bench for dmem_responder against a behavioural
//            memory model; second instance exercises zero wait states.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned WAITC = 2;
  localparam logic [31:0] BASE  = 32'h0;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;

  logic        req_valid0, req_ready0, req_we0;
  logic [31:0] req_addr0, req_wdata0;
  logic [3:0]  req_be0;
  logic        rsp_valid0, rsp_ready0, rsp_err0;
  logic [31:0] rsp_rdata0;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] m_data  [DEPTH];
  logic [3:0]  m_known [DEPTH];
  logic [31:0] rd;
  logic        er;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC), .ADDR_BASE(BASE)) u_dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0), .ADDR_BASE(BASE)) u_dut0 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid0), .req_ready(req_ready0), .req_we(req_we0),
    .req_addr(req_addr0), .req_wdata(req_wdata0), .req_be(req_be0),
    .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0),
    .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic model_err(input logic [31:0] a);
    if (a[1:0] != 2'b00) return 1'b1;
    if (a < BASE) return 1'b1;
    return ((a - BASE) / 4) >= DEPTH;
  endfunction

  function automatic logic [31:0] kmask(input logic [3:0] k);
    return {{8{k[3]}}, {8{k[2]}}, {8{k[1]}}, {8{k[0]}}};
  endfunction

  // One full transaction on the main instance, with `hold` cycles of
  // response backpressure before the handshake.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input int hold,
                        output logic [31:0] rdata_o, output logic err_o);
    int n;
    logic e;
    int idx;
    n = 0;
    while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_we    = 1'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_be    = 4'($urandom);
    n = 0;
    while (!rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
    chk("latency", 32'(n + 1), 32'(WAITC + 1));
    rdata_o = rsp_rdata;
    err_o   = rsp_err;
    e = model_err(addr);
    chk("err", {31'h0, err_o}, {31'h0, e});
    if (e || we) begin
      chk("rdata_zero", rdata_o, 32'h0);
    end else begin
      idx = int'((addr - BASE) / 4);
      chk("rdata", rdata_o & kmask(m_known[idx]), m_data[idx] & kmask(m_known[idx]));
    end
    if (!e && we) begin
      idx = int'((addr - BASE) / 4);
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          m_data[idx][8*i +: 8] = wdata[8*i +: 8];
          m_known[idx][i] = 1'b1;
        end
      end
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("hold_rdata", rsp_rdata, rdata_o);
      chk("hold_flags", {30'h0, rsp_valid, req_ready}, 32'h2);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("post_hs", {30'h0, rsp_valid, req_ready}, 32'h1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk(tag, {29'h0, req_ready, rsp_valid, rsp_err}, 32'h4);
    chk(tag, rsp_rdata, 32'h0);
  endtask

  initial begin : main
    logic [31:0] a;
    logic [31:0] s_addr  [6];
    logic [31:0] s_wdata [6];
    logic        s_we    [6];
    logic [31:0] s_exp   [6];
    int          iss, got, last, sel;
    logic        rdy_before;

    for (int i = 0; i < int'(DEPTH); i++) begin m_data[i] = 32'h0; m_known[i] = 4'h0; end
    reset = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; req_be = 4'h0;
    rsp_ready = 1'b0;
    req_valid0 = 1'b0; req_we0 = 1'b0; req_addr0 = 32'h0; req_wdata0 = 32'h0; req_be0 = 4'h0;
    rsp_ready0 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    reset = 1'b0;

    do_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd, er);
    do_req(1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er);
    chk("full_word", rd, 32'hDEADBEEF);

    do_req(1'b1, 32'h20, 32'h11223344, 4'hF, 0, rd, er);
    do_req(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 1, rd, er);
    do_req(1'b0, 32'h20, 32'h0, 4'h0, 0, rd, er);
    chk("byte_en", rd, 32'h11BB33DD);

    do_req(1'b0, 32'h22, 32'h0, 4'h0, 0, rd, er);
    chk("misalign", {31'h0, er}, 32'h1);
    do_req(1'b0, 4 * DEPTH, 32'h0, 4'h0, 0, rd, er);
    chk("oor", {31'h0, er}, 32'h1);
    do_req(1'b1, 4 * DEPTH, 32'h12345678, 4'hF, 0, rd, er);
    do_req(1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, 0, rd, er);
    chk("be0_err", {31'h0, er}, 32'h0);
    do_req(1'b0, 32'h20, 32'h0, 4'h0, 0, rd, er);
    chk("unchanged", rd, 32'h11BB33DD);

    do_req(1'b0, 32'h10, 32'h0, 4'h0, 5, rd, er);
    chk("hold_read", rd, 32'hDEADBEEF);

    // Reset while a write sits in its wait states: the write must be lost.
    do_req(1'b1, 32'h30, 32'hCAFEF00D, 4'hF, 0, rd, er);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h30; req_wdata = 32'h5; req_be = 4'hF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("in_wait", {30'h0, req_ready, rsp_valid}, 32'h0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk_reset_vals("mid_reset");
    repeat (3) begin
      @(posedge clk); #1;
      chk("no_rsp_after_rst", {31'h0, rsp_valid}, 32'h0);
    end
    do_req(1'b0, 32'h30, 32'h0, 4'h0, 0, rd, er);
    chk("lost_write", rd, 32'hCAFEF00D);

    for (int k = 0; k < 40; k++) begin
      sel = int'($urandom_range(0, 9));
      case (sel)
        0:       a = (32'd4 * $urandom_range(0, 15)) | $urandom_range(1, 3);
        1:       a = BASE + 4 * DEPTH + 32'd4 * $urandom_range(0, 100);
        2:       a = $urandom & 32'hFFFF_FFFC;
        default: a = BASE + 32'd4 * $urandom_range(0, 15);
      endcase
      do_req(1'($urandom), a, $urandom, 4'($urandom), int'($urandom_range(0, 3)), rd, er);
    end

    // Zero-wait instance: back-to-back stream with the response side always ready.
    for (int i = 0; i < 6; i++) begin
      s_we[i]    = (i < 3);
      s_addr[i]  = 32'h40 + 32'(4 * (i % 3));
      s_wdata[i] = $urandom;
    end
    for (int i = 0; i < 6; i++) s_exp[i] = (i < 3) ? 32'h0 : s_wdata[i - 3];
    rsp_ready0 = 1'b1;
    req_valid0 = 1'b1; req_we0 = s_we[0]; req_addr0 = s_addr[0];
    req_wdata0 = s_wdata[0]; req_be0 = 4'hF;
    iss = 0; got = 0; last = 0;
    for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
      rdy_before = req_ready0;
      @(posedge clk); #1;
      if (rdy_before && req_valid0) begin
        iss++;
        if (iss < 6) begin
          req_we0 = s_we[iss]; req_addr0 = s_addr[iss]; req_wdata0 = s_wdata[iss];
        end else begin
          req_valid0 = 1'b0;
        end
      end
      if (rsp_valid0) begin
        chk("b2b_rdata", rsp_rdata0, s_exp[got]);
        chk("b2b_err", {31'h0, rsp_err0}, 32'h0);
        if (got > 0) chk("b2b_gap", 32'(cyc - last), 32'd2);
        last = cyc;
        got++;
      end
    end
    chk("b2b_count", 32'(got), 32'd6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
